// File: rtl/linear_network_gather_seq_if.sv
// linear_network_gather_seq_if: node-to-sink gather bus bundle
// Ports (slave = gather block side):
//   i_valid    per-node valid, bit k is node k
//   i_data_bus node k word at [k*DATA_WIDTH +: DATA_WIDTH]
//   o_ready    per-node accept, one-hot or zero
//   o_valid    output slot holds a word
//   o_data_bus granted word
//   o_src_id   node index the word came from
//   i_ready    sink accepts the output word this cycle
//   i_en       enables new grants; the slot still drains when low
interface linear_network_gather_seq_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_NODE   = 4
);
    localparam int COMMMAND_WIDTH = $clog2(NUM_NODE);
    logic [NUM_NODE-1:0]            i_valid;
    logic [DATA_WIDTH*NUM_NODE-1:0] i_data_bus;
    logic [NUM_NODE-1:0]            o_ready;
    logic                           o_valid;
    logic [DATA_WIDTH-1:0]          o_data_bus;
    logic [COMMMAND_WIDTH-1:0]      o_src_id;
    logic                           i_ready;
    logic                           i_en;
    modport slave (
        input  i_valid, i_data_bus, i_ready, i_en,
        output o_ready, o_valid, o_data_bus, o_src_id
    );
    modport master (
        output i_valid, i_data_bus, i_ready, i_en,
        input  o_ready, o_valid, o_data_bus, o_src_id
    );
endinterface

// File: rtl/linear_network_gather_seq.sv
// linear_network_gather_seq: round-robin gather of NUM_NODE node words into one registered output slot
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  gather bundle (slave modport): node valid/data/ready in, output slot valid/data/src id out,
//        sink ready and grant enable in
module linear_network_gather_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_NODE   = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    linear_network_gather_seq_if.slave         bus
);
    localparam int COMMMAND_WIDTH = $clog2(NUM_NODE);
    localparam logic [COMMMAND_WIDTH-1:0] LAST = COMMMAND_WIDTH'(NUM_NODE - 1);

    logic                      o_valid_q, o_valid_d;
    logic [DATA_WIDTH-1:0]     o_data_q, o_data_d;
    logic [COMMMAND_WIDTH-1:0] o_src_q, o_src_d;
    logic [COMMMAND_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [COMMMAND_WIDTH-1:0] gnt, cand;
    logic                      found, load;

    // Walk the nodes starting at rr_ptr, wrapping at NUM_NODE (not at 2^width),
    // and take the first valid one.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        cand  = rr_ptr_q;
        for (int i = 0; i < NUM_NODE; i++) begin
            if (!found && bus.i_valid[cand]) begin
                gnt   = cand;
                found = 1'b1;
            end
            cand = (cand == LAST) ? '0 : cand + 1'b1;
        end
    end

    // Gating with rst keeps o_ready low while reset is held.
    assign load = !rst & bus.i_en & (!o_valid_q | bus.i_ready) & found;

    always_comb begin
        o_valid_d = load | (o_valid_q & !bus.i_ready);
        o_data_d  = load ? bus.i_data_bus[gnt*DATA_WIDTH +: DATA_WIDTH] : o_data_q;
        o_src_d   = load ? gnt : o_src_q;
        rr_ptr_d  = load ? ((gnt == LAST) ? '0 : gnt + 1'b1) : rr_ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_src_q   <= '0;
            rr_ptr_q  <= '0;
        end else begin
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            o_src_q   <= o_src_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign bus.o_ready    = load ? (NUM_NODE'(1) << gnt) : '0;
    assign bus.o_valid    = o_valid_q;
    assign bus.o_data_bus = o_data_q;
    assign bus.o_src_id   = o_src_q;
endmodule

// File: tb/tb_linear_network_gather_seq.sv
// tb_linear_network_gather_seq: directed self-checking bench for the gather block (4-node and 3-node instances)
module tb_linear_network_gather_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    linear_network_gather_seq_if #(.DATA_WIDTH(32), .NUM_NODE(4)) b4 ();
    linear_network_gather_seq_if #(.DATA_WIDTH(32), .NUM_NODE(3)) b3 ();

    linear_network_gather_seq #(.DATA_WIDTH(32), .NUM_NODE(4)) u4 (.clk(clk), .rst(rst), .bus(b4));
    linear_network_gather_seq #(.DATA_WIDTH(32), .NUM_NODE(3)) u3 (.clk(clk), .rst(rst), .bus(b3));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        b4.i_valid    = '0;
        b4.i_data_bus = {32'h13, 32'h12, 32'h11, 32'h10};
        b4.i_ready    = 1'b1;
        b4.i_en       = 1'b1;
        b3.i_valid    = '0;
        b3.i_data_bus = {32'hA2, 32'hA1, 32'hA0};
        b3.i_ready    = 1'b1;
        b3.i_en       = 1'b1;
        tick();
        tick();
        #1;
        chk("rst_valid", 64'(b4.o_valid), 64'd0);
        chk("rst_data", 64'(b4.o_data_bus), 64'd0);
        chk("rst_src", 64'(b4.o_src_id), 64'd0);
        tick();
        rst = 1'b0;

        // single node 2
        b4.i_valid    = 4'b0100;
        b4.i_data_bus = {32'h13, 32'hDEADBEEF, 32'h11, 32'h10};
        #1;
        chk("t1_ready", 64'(b4.o_ready), 64'b0100);
        chk("t1_valid_pre", 64'(b4.o_valid), 64'd0);
        tick();
        b4.i_valid    = '0;
        b4.i_data_bus = {32'h13, 32'h12, 32'h11, 32'h10};
        #1;
        chk("t1_valid", 64'(b4.o_valid), 64'd1);
        chk("t1_data", 64'(b4.o_data_bus), 64'hDEADBEEF);
        chk("t1_src", 64'(b4.o_src_id), 64'd2);
        chk("t1_ready_idle", 64'(b4.o_ready), 64'd0);

        // all valid: rr_ptr is 3 after the node-2 grant, so grants run 3,0,1,2,3,0
        b4.i_valid = 4'hF;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("t2_ready", 64'(b4.o_ready), 64'(4'b0001 << ((3 + i) % 4)));
            tick();
            chk("t2_valid", 64'(b4.o_valid), 64'd1);
            chk("t2_src", 64'(b4.o_src_id), 64'((3 + i) % 4));
            chk("t2_data", 64'(b4.o_data_bus), 64'(32'h10 + (3 + i) % 4));
        end

        // NUM_NODE=3 wrap: node 1 first puts rr_ptr at 2
        b3.i_valid = 3'b010;
        #1;
        chk("t5_ready1", 64'(b3.o_ready), 64'b010);
        tick();
        b3.i_valid = 3'b101;
        #1;
        chk("t5_src1", 64'(b3.o_src_id), 64'd1);
        chk("t5_ready2", 64'(b3.o_ready), 64'b100);
        tick();
        b3.i_valid = 3'b001;
        #1;
        chk("t5_src2", 64'(b3.o_src_id), 64'd2);
        chk("t5_data2", 64'(b3.o_data_bus), 64'hA2);
        chk("t5_ready0", 64'(b3.o_ready), 64'b001);
        tick();
        b3.i_valid = 3'b000;
        #1;
        chk("t5_src0", 64'(b3.o_src_id), 64'd0);
        chk("t5_data0", 64'(b3.o_data_bus), 64'hA0);

        // backpressure: get src 1 into the slot (rr_ptr is 1 here)
        b4.i_valid = 4'b0010;
        #1;
        chk("t3_ready1", 64'(b4.o_ready), 64'b0010);
        tick();
        b4.i_valid = 4'b1001;
        b4.i_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_bp_ready", 64'(b4.o_ready), 64'd0);
            chk("t3_bp_valid", 64'(b4.o_valid), 64'd1);
            chk("t3_bp_src", 64'(b4.o_src_id), 64'd1);
            chk("t3_bp_data", 64'(b4.o_data_bus), 64'h11);
            tick();
        end
        b4.i_ready = 1'b1;
        #1;
        chk("t3_ready3", 64'(b4.o_ready), 64'b1000);
        tick();
        b4.i_valid = 4'b0001;
        #1;
        chk("t3_src3", 64'(b4.o_src_id), 64'd3);
        chk("t3_ready0", 64'(b4.o_ready), 64'b0001);
        tick();
        #1;
        chk("t3_src0", 64'(b4.o_src_id), 64'd0);
        chk("t3_data0", 64'(b4.o_data_bus), 64'h10);

        // i_en low: pending word drains, no grants; rr_ptr held at 1
        b4.i_valid = 4'hF;
        b4.i_en    = 1'b0;
        #1;
        chk("t4_ready_off", 64'(b4.o_ready), 64'd0);
        tick();
        chk("t4_drained", 64'(b4.o_valid), 64'd0);
        chk("t4_ready_off2", 64'(b4.o_ready), 64'd0);
        tick();
        chk("t4_still_empty", 64'(b4.o_valid), 64'd0);
        b4.i_en = 1'b1;
        #1;
        chk("t4_ready_resume", 64'(b4.o_ready), 64'b0010);
        tick();
        chk("t4_src", 64'(b4.o_src_id), 64'd1);
        chk("t4_valid", 64'(b4.o_valid), 64'd1);

        // reset mid-operation, then lowest valid node wins from rr_ptr 0
        b4.i_valid = 4'b1100;
        b4.i_ready = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("t6_valid_async", 64'(b4.o_valid), 64'd0);
        chk("t6_ready_rst", 64'(b4.o_ready), 64'd0);
        tick();
        rst        = 1'b0;
        b4.i_ready = 1'b1;
        #1;
        chk("t6_ready_after", 64'(b4.o_ready), 64'b0100);
        tick();
        chk("t6_src", 64'(b4.o_src_id), 64'd2);
        chk("t6_data", 64'(b4.o_data_bus), 64'h12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
